// File: rtl/fifo_pkg.sv
// fifo_pkg -- shared defaults and helpers for the parametrised synchronous FIFO.
//   DEF_DATA_W / DEF_DEPTH : default word width and entry count
//   DEF_AF_MARGIN          : almost_full default sits this many entries below full
//   DEF_AE_LEVEL           : almost_empty default threshold
//   count_w()              : width of an occupancy counter able to hold 0..depth
//   cnt_op_t               : occupancy update selected each cycle
package fifo_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_DEPTH     = 64;
    localparam int unsigned DEF_AF_MARGIN = 4;
    localparam int unsigned DEF_AE_LEVEL  = 4;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_t;

    function automatic int unsigned count_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem -- DEPTH x DATA_W storage array, synchronous write, combinational read.
// Ports:
//   clk    rising-edge clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  mem[raddr], combinational
// Contents are never reset.
module fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param -- parametrised single-clock FIFO with exact occupancy,
// programmable almost flags and sticky overflow/underflow.
// Optional build macro SYNC_FIFO_FWFT_EN: first-word fall-through output
// (fifo_out shows the head word whenever not empty). Without it fifo_out is a
// register loaded on each accepted read (1-cycle latency).
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   wr, fifo_in   write request and data
//   rd, fifo_out  read request and data
//   fifo_full     count == DEPTH        fifo_empty    count == 0
//   almost_full   count >= AF_LEVEL     almost_empty  count <= AE_LEVEL
//   fifo_count    occupancy 0..DEPTH
//   overflow      sticky: write requested but not accepted
//   underflow     sticky: read requested while empty
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter  int unsigned DATA_W   = DEF_DATA_W,
    parameter  int unsigned DEPTH    = DEF_DEPTH,
    parameter  int unsigned AF_LEVEL = DEPTH - DEF_AF_MARGIN,
    parameter  int unsigned AE_LEVEL = DEF_AE_LEVEL,
    localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DATA_W-1:0] fifo_in,
    input  logic              rd,
    output logic [DATA_W-1:0] fifo_out,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned CNT_W = count_w(DEPTH);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              ovf_q;
    logic              udf_q;
    logic [DATA_W-1:0] mem_rdata;
    logic              rd_acc;
    logic              wr_acc;
    cnt_op_t           cnt_op;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = rd & ~fifo_empty;
    assign wr_acc = wr & (~fifo_full | rd_acc);

    always_comb begin
        cnt_op = CNT_HOLD;
        if (wr_acc && !rd_acc) begin
            cnt_op = CNT_INC;
        end else if (rd_acc && !wr_acc) begin
            cnt_op = CNT_DEC;
        end
    end

    // rst gates the write so the request sampled on the reset edge is dropped.
    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc & ~rst),
        .waddr (wr_ptr),
        .wdata (fifo_in),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case (cnt_op)
                CNT_INC: count_q <= count_q + 1'b1;
                CNT_DEC: count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (wr && !wr_acc) begin
                ovf_q <= 1'b1;
            end
            if (rd && fifo_empty) begin
                udf_q <= 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign fifo_out = mem_rdata;
`else
    logic [DATA_W-1:0] out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else if (rd_acc) begin
            out_q <= mem_rdata;
        end
    end

    assign fifo_out = out_q;
`endif

    assign fifo_count   = count_q;
    assign fifo_full    = (count_q == FULL_CNT);
    assign fifo_empty   = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock synchronous FIFO; next generation of the team's 64x8 byte FIFO.
- Generalised data width and depth, plus:
  - exact occupancy count
  - programmable almost-full/almost-empty flags
  - sticky overflow/underflow error flags
  - write acceptance while full if a read is accepted in the same cycle
- Sits between byte/word producers and consumers on one clock domain.

Parameters:
- DATA_W, 8, data word width in bits (>=1)
- DEPTH, 64, number of entries; power of two, >=4
- ADDR_W, $clog2(DEPTH), pointer width; derived, never overridden
- AF_LEVEL, DEPTH-4, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- wr  in  1  write request
- fifo_in  in  DATA_W  write data
- rd  in  1  read request
- fifo_out  out  DATA_W  read data
- fifo_full  out  1  count == DEPTH
- fifo_empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- fifo_count  out  ADDR_W+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write requested but not accepted
- underflow  out  1  sticky: read requested while empty

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-high; all state changes occur on rising clk.
- Reset values:
  - rd/wr pointers, fifo_count, fifo_out, overflow, underflow = 0
  - fifo_empty = 1, almost_empty = 1, fifo_full = 0, almost_full = 0
  - Memory contents are not reset.
- Acceptance:
  - rd_acc = rd & !fifo_empty
  - wr_acc = wr & (!fifo_full | rd_acc); a full FIFO with a simultaneous accepted read also accepts the write.
- Empty with rd & wr in the same cycle:
  - Write accepted, read rejected (no bypass); underflow sets.
  - Count becomes 1.
- Count update:
  - +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
  - fifo_count never exceeds DEPTH and never wraps below 0.
- Pointers:
  - ADDR_W bits; increment by 1 on the respective accept.
  - Wrap naturally DEPTH-1 -> 0.
- Write: on wr_acc, mem[wr_ptr] <= fifo_in.
- Read (default, registered mode):
  - On rd_acc, fifo_out <= mem[rd_ptr]; data is visible the cycle after the read is accepted (1-cycle latency).
  - Otherwise fifo_out holds its value.
- Flags:
  - All flags are combinational decodes of fifo_count (registered count), so they are valid in the cycle after the accepting edge.
- overflow:
  - Sets on wr & !wr_acc.
  - underflow sets on rd & fifo_empty.
  - Both hold until rst; no other clear.
- Reset mid-operation: contents are logically discarded, all outputs return to reset values on that edge, and the requests sampled on that edge are ignored.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN
- Defined: first-word fall-through.
  - fifo_out always presents mem[rd_ptr] whenever !fifo_empty (0-cycle latency); rd acts as "pop".
  - A word written into an empty FIFO appears on fifo_out the cycle after the write.
  - fifo_out value while empty is don't-care; the bench must not check it.
- Undefined: registered 1-cycle-latency read as described above.

Decomposition:
- Package fifo_pkg:
  - default DATA_W/DEPTH constants
  - count-width helper (ADDR_W+1)
  - default AF/AE margin constants
- Sub-module fifo_mem: DEPTH x DATA_W dual-port array with synchronous write and read-address input; the top instantiates it and owns pointers, count, flags and output register.

Test Plan:
- Reset then idle (DATA_W=8, DEPTH=8, AF=6, AE=2) -> fifo_empty=1, almost_empty=1, fifo_count=0, fifo_out=0, overflow=underflow=0.
- Write 0x01..0x08 on 8 consecutive cycles -> fifo_full=1, count=8, almost_full high from count 6. Then 9th write 0xFF -> not stored, overflow=1, count stays 8.
- Read 8 times after the fill -> fifo_out 0x01..0x08 each one cycle after rd (FWFT: same cycle). fifo_empty=1 afterwards. Extra rd -> underflow=1.
- Full (8 entries) with rd=wr=1 for 3 cycles writing 0xA0..0xA2 -> count stays 8, no overflow. Later reads return 0x04..0x08 then 0xA0..0xA2.
- Wrap-around: 20 cycles of interleaved single write/read pairs -> pointers wrap past 7, data order preserved, count oscillates 0/1.
- Assert rst at count=5 with wr=1 -> next cycle count=0, fifo_empty=1, sticky flags cleared, and the write is not stored.
